// File: rtl/value_watchdog.sv
// value_watchdog: arms on a start request, then watches a monitored signal for a
// masked match against a latched goal value. Once the value matches, it must keep
// matching for a configurable number of extra cycles. The outcome is reported as
// a one-cycle done pulse, together with exactly one sticky flag: pass, flake or
// timeout.
//
// Optional build macro VALUE_WATCHDOG_STATS_EN adds saturating per-outcome
// completion counters (pass_cnt, flake_cnt, tmo_cnt).
module value_watchdog #(
  parameter int WIDTH  = 16,
  parameter int TMO_W  = 16,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  goal,
  input  logic [WIDTH-1:0]  mask,
  input  logic [TMO_W-1:0]  timeout,
  input  logic [HOLD_W-1:0] hold_cyc,
  input  logic              hold_req,
  input  logic [WIDTH-1:0]  sig,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              flake,
  output logic              tmo
`ifdef VALUE_WATCHDOG_STATS_EN
  ,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       flake_cnt,
  output logic [15:0]       tmo_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    HOLD   = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t              state;

  // Configuration latched when start is accepted.
  logic [WIDTH-1:0]    goal_q;
  logic [WIDTH-1:0]    mask_q;
  logic [TMO_W-1:0]    tmo_lim_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                hold_req_q;

  // Progress counters.
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;

  logic                match;

  // Index of the last WATCH compare that is still allowed to miss.
  // A timeout of 0 behaves like 1, so at least one compare always happens.
  // Storing the limit pre-decremented means the counter only has to reach
  // timeout-1, so it never wraps, even at the largest timeout value.
  function automatic logic [TMO_W-1:0] tmo_limit(input logic [TMO_W-1:0] t);
    return (t == '0) ? '0 : t - TMO_W'(1);
  endfunction

  // Masked equality: only bits set in mask_q take part, so an all-zero mask
  // always matches.
  assign match = (((sig ^ goal_q) & mask_q) == '0);

  // Main control FSM. All outputs are registered here, so done and the result
  // flag rise on the same edge that enters REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      flake      <= 1'b0;
      tmo        <= 1'b0;
      goal_q     <= '0;
      mask_q     <= '0;
      tmo_lim_q  <= '0;
      hold_q     <= '0;
      hold_req_q <= 1'b0;
      tmo_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            goal_q     <= goal;
            mask_q     <= mask;
            tmo_lim_q  <= tmo_limit(timeout);
            hold_q     <= hold_cyc;
            hold_req_q <= hold_req;
            tmo_cnt_q  <= '0;
            hold_cnt_q <= '0;
            pass       <= 1'b0;
            flake      <= 1'b0;
            tmo        <= 1'b0;
            busy       <= 1'b1;
            state      <= WATCH;
          end
        end

        WATCH: begin
          if (match) begin
            hold_cnt_q <= '0;
            state      <= HOLD;
          end else if (tmo_cnt_q == tmo_lim_q) begin
            tmo   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= REPORT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end

        HOLD: begin
          // The timeout counter is frozen here. If the match is lost and we
          // go back to WATCH, the counter resumes where it left off.
          if (match) begin
            if (hold_cnt_q == hold_q) begin
              pass  <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= REPORT;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end else if (hold_req_q) begin
            flake <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= REPORT;
          end else begin
            state <= WATCH;
          end
        end

        REPORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VALUE_WATCHDOG_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Outcome statistics. Each counter is bumped while its done pulse is high,
  // so it becomes visible one cycle after the report. Only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt  <= '0;
      flake_cnt <= '0;
      tmo_cnt   <= '0;
    end else if (done) begin
      if (pass)  pass_cnt  <= sat_inc(pass_cnt);
      if (flake) flake_cnt <= sat_inc(flake_cnt);
      if (tmo)   tmo_cnt   <= sat_inc(tmo_cnt);
    end
  end
`endif

endmodule
